spi_mem_fsm: RTL and testbench

- Parametrised control FSM for the SPI-slave memory path. Sits between the input conditioners and shift register, and the data memory / MISO buffer.
- Counts conditioned SCLK edges to frame an address+R/W header, then one or more data frames.
- Generates the address-latch, memory-write, parallel-load and MISO-enable strobes.
- Generalises the fixed 8-bit transaction to configurable address/data width, memory read latency and an auto-increment burst mode.

---
 rtl/spi_mem_fsm.sv | 209 ++++++++++++++++++++
 tb/tb_spi_mem_fsm.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mem_fsm.sv
// -----------------------------------------------------------------------------
// spi_mem_fsm
//
// Control FSM for the SPI-slave memory path. It counts conditioned SCLK edges
// to frame an address + R/W header, then one or more data frames. It drives
// the strobes that latch the address, write memory, load the shift register
// and enable the MISO driver.
//
// Parameters
//   ADDR_BITS : address width; the header is ADDR_BITS+1 bits, R/W in the LSB
//   DATA_BITS : data frame length in bits
//   READ_LAT  : clk cycles (>= 1) spent in READ_WAIT before the load strobe
//   BURST_EN  : 1 = back-to-back data frames with auto-incremented address
//               while chip select stays asserted; 0 = one frame per select
//
// Ports
//   clk                 in   system clock, all logic on posedge
//   reset_n             in   synchronous active-low reset
//   cs_conditioned      in   conditioned chip select, 1 = deselected (abort)
//   peripheralClkEdge   in   one-clk pulse per SCLK sampling edge
//   parallelDataOut     in   shift-register parallel contents
//   Address_LatchEnable out  one-cycle strobe: header latched into mem_addr
//   writeEnableData     out  one-cycle memory write strobe
//   parallelLoad        out  one-cycle strobe: load memory data into shifter
//   MISO_buffer_EN      out  MISO tristate enable, high while read shifting
//   mem_addr            out  current transaction address (burst-incremented)
//   rw_flag             out  latched R/W bit, 1 = read
//   frame_done          out  one-cycle pulse at the end of every data frame
//
// All outputs are registered: a strobe decided while in state S is high
// during the clk cycle that follows S.
// -----------------------------------------------------------------------------
module spi_mem_fsm #(
  parameter int ADDR_BITS = 7,
  parameter int DATA_BITS = 8,
  parameter int READ_LAT  = 1,
  parameter bit BURST_EN  = 1'b1,
  localparam int PW = ((ADDR_BITS + 1) > DATA_BITS) ? (ADDR_BITS + 1) : DATA_BITS,
  localparam int CW = $clog2(PW + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cs_conditioned,
  input  logic                 peripheralClkEdge,
  input  logic [PW-1:0]        parallelDataOut,
  output logic                 Address_LatchEnable,
  output logic                 writeEnableData,
  output logic                 parallelLoad,
  output logic                 MISO_buffer_EN,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 rw_flag,
  output logic                 frame_done
);

  // Wait counter only has to reach READ_LAT-1.
  localparam int WW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  localparam logic [CW-1:0]        HDR_LIM  = CW'(ADDR_BITS + 1);
  localparam logic [CW-1:0]        DAT_LIM  = CW'(DATA_BITS);
  localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
  localparam logic [WW-1:0]        WAIT_LIM = WW'(READ_LAT - 1);
  localparam logic [WW-1:0]        WAIT_ONE = WW'(1);
  localparam logic [ADDR_BITS-1:0] ADDR_ONE = ADDR_BITS'(1);

  // Four-bit encoding leaves spare codes; any of them recovers to GET_ADDR.
  typedef enum logic [3:0] {
    GET_ADDR     = 4'd0,
    GOT_ADDR     = 4'd1,
    READ_WAIT    = 4'd2,
    READ_LOAD    = 4'd3,
    READ_SHIFT   = 4'd4,
    WRITE_SHIFT  = 4'd5,
    WRITE_COMMIT = 4'd6,
    HOLD         = 4'd7
  } state_t;

  state_t         state;
  logic [CW-1:0]  counter;
  logic [WW-1:0]  wait_cnt;
  // Burst write: the increment is deferred one cycle so the write strobe
  // sees the address of the frame it commits.
  logic           inc_pend;

  // Only the header bits are decoded here; wider data frames go straight
  // from the shift register to memory.
  logic           pdo_unused;
  assign pdo_unused = ^parallelDataOut;

  // Address increments wrap modulo 2^ADDR_BITS.
  function automatic logic [ADDR_BITS-1:0] addr_inc(input logic [ADDR_BITS-1:0] a);
    return a + ADDR_ONE;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state               <= GET_ADDR;
      counter             <= '0;
      wait_cnt            <= '0;
      inc_pend            <= 1'b0;
      mem_addr            <= '0;
      rw_flag             <= 1'b0;
      Address_LatchEnable <= 1'b0;
      writeEnableData     <= 1'b0;
      parallelLoad        <= 1'b0;
      MISO_buffer_EN      <= 1'b0;
      frame_done          <= 1'b0;
    end else begin
      Address_LatchEnable <= 1'b0;
      writeEnableData     <= 1'b0;
      parallelLoad        <= 1'b0;
      MISO_buffer_EN      <= 1'b0;
      frame_done          <= 1'b0;

      if (cs_conditioned) begin
        // Deselect aborts from any state; address and R/W are kept.
        state    <= GET_ADDR;
        counter  <= '0;
        wait_cnt <= '0;
        inc_pend <= 1'b0;
      end else begin
        case (state)
          GET_ADDR: begin
            // Edges arriving once the limit is reached are dropped.
            if (counter == HDR_LIM) begin
              state <= GOT_ADDR;
            end else if (peripheralClkEdge) begin
              counter <= counter + CNT_ONE;
            end
          end

          GOT_ADDR: begin
            counter             <= '0;
            wait_cnt            <= '0;
            Address_LatchEnable <= 1'b1;
            mem_addr            <= parallelDataOut[ADDR_BITS:1];
            rw_flag             <= parallelDataOut[0];
            state               <= parallelDataOut[0] ? READ_WAIT : WRITE_SHIFT;
          end

          READ_WAIT: begin
            if (wait_cnt == WAIT_LIM) begin
              wait_cnt <= '0;
              state    <= READ_LOAD;
            end else begin
              wait_cnt <= wait_cnt + WAIT_ONE;
            end
          end

          READ_LOAD: begin
            parallelLoad <= 1'b1;
            state        <= READ_SHIFT;
          end

          READ_SHIFT: begin
            MISO_buffer_EN <= 1'b1;
            if (counter == DAT_LIM) begin
              frame_done <= 1'b1;
              counter    <= '0;
              if (BURST_EN) begin
                mem_addr <= addr_inc(mem_addr);
                state    <= READ_WAIT;
              end else begin
                state <= HOLD;
              end
            end else if (peripheralClkEdge) begin
              counter <= counter + CNT_ONE;
            end
          end

          WRITE_SHIFT: begin
            if (inc_pend) begin
              mem_addr <= addr_inc(mem_addr);
              inc_pend <= 1'b0;
            end
            if (counter == DAT_LIM) begin
              state <= WRITE_COMMIT;
            end else if (peripheralClkEdge) begin
              counter <= counter + CNT_ONE;
            end
          end

          WRITE_COMMIT: begin
            writeEnableData <= 1'b1;
            frame_done      <= 1'b1;
            counter         <= '0;
            if (BURST_EN) begin
              inc_pend <= 1'b1;
              state    <= WRITE_SHIFT;
            end else begin
              state <= HOLD;
            end
          end

          HOLD: begin
            // Parked until chip select is released.
          end

          default: begin
            state    <= GET_ADDR;
            counter  <= '0;
            wait_cnt <= '0;
            inc_pend <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_mem_fsm.sv
// -----------------------------------------------------------------------------
// tb_spi_mem_fsm
//
// Three spi_mem_fsm instances share one stimulus stream:
//   u_dut0 : ADDR 7, DATA 8,  READ_LAT 1, burst on
//   u_dut1 : ADDR 7, DATA 8,  READ_LAT 3, burst off
//   u_dut2 : ADDR 9, DATA 16, READ_LAT 1, burst off
// 'sel' chooses which instance the monitor watches. Expected strobe events are
// queued as stimulus is issued; the monitor pops one per observed strobe and
// compares address, R/W, edges since the previous event and cycle gap.
// -----------------------------------------------------------------------------
module tb_spi_mem_fsm;

  localparam int K_ALE = 0;
  localparam int K_PL  = 1;
  localparam int K_WE  = 2;
  localparam int K_FD  = 3;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        cs;
  logic        pe;
  logic [15:0] pdo;
  int          sel;

  logic       d0_ale, d0_we, d0_pl, d0_miso, d0_rw, d0_fd;
  logic [6:0] d0_addr;
  logic       d1_ale, d1_we, d1_pl, d1_miso, d1_rw, d1_fd;
  logic [6:0] d1_addr;
  logic       d2_ale, d2_we, d2_pl, d2_miso, d2_rw, d2_fd;
  logic [8:0] d2_addr;

  spi_mem_fsm #(.ADDR_BITS(7), .DATA_BITS(8), .READ_LAT(1), .BURST_EN(1'b1)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .cs_conditioned(cs), .peripheralClkEdge(pe),
    .parallelDataOut(pdo[7:0]), .Address_LatchEnable(d0_ale), .writeEnableData(d0_we),
    .parallelLoad(d0_pl), .MISO_buffer_EN(d0_miso), .mem_addr(d0_addr),
    .rw_flag(d0_rw), .frame_done(d0_fd)
  );

  spi_mem_fsm #(.ADDR_BITS(7), .DATA_BITS(8), .READ_LAT(3), .BURST_EN(1'b0)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .cs_conditioned(cs), .peripheralClkEdge(pe),
    .parallelDataOut(pdo[7:0]), .Address_LatchEnable(d1_ale), .writeEnableData(d1_we),
    .parallelLoad(d1_pl), .MISO_buffer_EN(d1_miso), .mem_addr(d1_addr),
    .rw_flag(d1_rw), .frame_done(d1_fd)
  );

  spi_mem_fsm #(.ADDR_BITS(9), .DATA_BITS(16), .READ_LAT(1), .BURST_EN(1'b0)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .cs_conditioned(cs), .peripheralClkEdge(pe),
    .parallelDataOut(pdo), .Address_LatchEnable(d2_ale), .writeEnableData(d2_we),
    .parallelLoad(d2_pl), .MISO_buffer_EN(d2_miso), .mem_addr(d2_addr),
    .rw_flag(d2_rw), .frame_done(d2_fd)
  );

  // Outputs of the instance under observation.
  logic       m_ale, m_we, m_pl, m_miso, m_rw, m_fd;
  logic [8:0] m_addr;

  always_comb begin
    m_ale  = d0_ale;  m_we = d0_we;  m_pl = d0_pl;  m_miso = d0_miso;
    m_rw   = d0_rw;   m_fd = d0_fd;  m_addr = {2'b00, d0_addr};
    case (sel)
      1: begin
        m_ale  = d1_ale;  m_we = d1_we;  m_pl = d1_pl;  m_miso = d1_miso;
        m_rw   = d1_rw;   m_fd = d1_fd;  m_addr = {2'b00, d1_addr};
      end
      2: begin
        m_ale  = d2_ale;  m_we = d2_we;  m_pl = d2_pl;  m_miso = d2_miso;
        m_rw   = d2_rw;   m_fd = d2_fd;  m_addr = d2_addr;
      end
      default: ;
    endcase
  end

  typedef struct {
    int kind;
    int addr;    // -1 = don't care
    int rw;      // -1 = don't care
    int nedges;  // edges seen since previous event / abort, -1 = don't care
    int gap;     // cycles since previous event, -1 = don't care
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  int   cyc       = 0;
  int   last_ev   = 0;
  int   edge_cnt  = 0;
  int   miso_drop = 0;
  bit   in_read   = 1'b0;

  function automatic string kname(input int k);
    case (k)
      K_ALE:   return "ALE";
      K_PL:    return "PLOAD";
      K_WE:    return "WRITE";
      K_FD:    return "FDONE";
      default: return "UNKNOWN";
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
    end
  endtask

  task automatic expect_ev(input int k, input int a, input int rw, input int ne, input int g);
    exp_t e;
    e.kind = k; e.addr = a; e.rw = rw; e.nedges = ne; e.gap = g;
    exp_q.push_back(e);
  endtask

  task automatic take_event(input int k);
    exp_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_%s at cycle %0d: got addr=%0h rw=%0d, expected no event",
               kname(k), cyc, m_addr, m_rw);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k ||
          (e.addr   >= 0 && e.addr   != int'(m_addr)) ||
          (e.rw     >= 0 && e.rw     != int'(m_rw))   ||
          (e.nedges >= 0 && e.nedges != edge_cnt)     ||
          (e.gap    >= 0 && e.gap    != cyc - last_ev)) begin
        n_fail++;
        $display("FAIL event_%s at cycle %0d: got addr=%0h rw=%0d edges=%0d gap=%0d, expected %s addr=%0h rw=%0d edges=%0d gap=%0d",
                 kname(k), cyc, m_addr, m_rw, edge_cnt, cyc - last_ev,
                 kname(e.kind), e.addr, e.rw, e.nedges, e.gap);
      end
    end
    last_ev  = cyc;
    edge_cnt = 0;
  endtask

  // Monitor: samples 2 time units after each rising edge.
  always @(posedge clk) begin
    #2;
    cyc++;
    if (!reset_n || cs) in_read = 1'b0;
    if (in_read && !m_miso) miso_drop++;
    if (m_ale) take_event(K_ALE);
    if (m_pl)  take_event(K_PL);
    if (m_we)  take_event(K_WE);
    if (m_fd) begin
      take_event(K_FD);
      if (in_read) begin
        check("miso_gaps_during_read", miso_drop, 0);
        check("miso_at_frame_done", m_miso, 1'b1);
        in_read = 1'b0;
      end
    end
    if (m_pl) begin
      in_read   = 1'b1;
      miso_drop = 0;
    end
    if (pe) edge_cnt++;
    if (!reset_n || cs) edge_cnt = 0;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic edges(input int n);
    repeat (n) begin
      @(negedge clk); pe = 1'b1;
      @(negedge clk); pe = 1'b0;
    end
  endtask

  task automatic cs_pulse();
    @(negedge clk); cs = 1'b1;
    @(negedge clk); cs = 1'b0;
    idle(2);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; cs = 1'b0; pe = 1'b0; pdo = '0; sel = 0;
    idle(3);
    check("reset_ale",   d0_ale,  1'b0);
    check("reset_we",    d0_we,   1'b0);
    check("reset_pload", d0_pl,   1'b0);
    check("reset_miso",  d0_miso, 1'b0);
    check("reset_fdone", d0_fd,   1'b0);
    check("reset_addr",  d0_addr, 7'h00);
    check("reset_rw",    d0_rw,   1'b0);
    check("reset_addr2", d2_addr, 9'h000);
    reset_n = 1'b1;
    idle(2);

    // Reset in the middle of a write frame (4 data edges in).
    pdo = 16'h0054;
    expect_ev(K_ALE, 'h2A, 0, 8, -1);
    edges(8); idle(6); edges(4);
    @(negedge clk) reset_n = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    check("midwrite_reset_addr", d0_addr, 7'h00);
    check("midwrite_reset_rw",   d0_rw,   1'b0);
    idle(10);

    // Chip-select abort after 5 data edges, then a clean burst read header.
    pdo = 16'h0010;
    expect_ev(K_ALE, 'h08, 0, 8, -1);
    edges(8); idle(6); edges(5);
    cs_pulse();
    pdo = 16'h0023;
    expect_ev(K_ALE, 'h11, 1, 8, -1);
    expect_ev(K_PL,  'h11, 1, 0, 2);
    expect_ev(K_FD,  'h12, 1, 8, -1);
    expect_ev(K_PL,  'h12, 1, 0, 2);
    edges(8); idle(8); edges(8); idle(6);
    cs_pulse();
    check("cs_holds_addr", d0_addr, 7'h12);
    check("cs_holds_rw",   d0_rw,   1'b1);

    // Burst write starting at 0x7F: wraps to 0x00, 0x01.
    pdo = 16'h00FE;
    expect_ev(K_ALE, 'h7F, 0, 8, -1);
    expect_ev(K_WE,  'h7F, 0, 8, -1);
    expect_ev(K_FD,  'h7F, 0, 0, 0);
    expect_ev(K_WE,  'h00, 0, 8, -1);
    expect_ev(K_FD,  'h00, 0, 0, 0);
    expect_ev(K_WE,  'h01, 0, 8, -1);
    expect_ev(K_FD,  'h01, 0, 0, 0);
    edges(8);
    repeat (3) begin
      idle(6); edges(8);
    end
    idle(6);
    cs_pulse();

    // Single write and single read on the non-burst, READ_LAT=3 instance.
    sel = 1;
    idle(2);
    pdo = 16'h0054;
    expect_ev(K_ALE, 'h2A, 0, 8, -1);
    expect_ev(K_WE,  'h2A, 0, 8, -1);
    expect_ev(K_FD,  'h2A, 0, 0, 0);
    edges(8); idle(6); edges(8); idle(6);
    edges(8); idle(4);
    check("single_write_addr", d1_addr, 7'h2A);
    cs_pulse();

    pdo = 16'h0055;
    expect_ev(K_ALE, 'h2A, 1, 8, -1);
    expect_ev(K_PL,  'h2A, 1, 0, 4);
    expect_ev(K_FD,  'h2A, 1, 8, -1);
    edges(8); idle(10); edges(4);
    check("read_miso_mid", d1_miso, 1'b1);
    edges(4); idle(6);
    check("hold_miso_off", d1_miso, 1'b0);
    edges(8); idle(2);
    check("single_read_addr", d1_addr, 7'h2A);
    cs_pulse();

    // Width sweep: 10-bit header with an 11th edge landing in GOT_ADDR,
    // followed by a 16-bit data frame.
    sel = 2;
    idle(2);
    pdo = 16'hFF4A;
    expect_ev(K_ALE, 'h1A5, 0, 10, -1);
    expect_ev(K_WE,  'h1A5, 0, 17, -1);
    expect_ev(K_FD,  'h1A5, 0, 0, 0);
    edges(11); idle(6); edges(16); idle(8);
    check("wide_addr", d2_addr, 9'h1A5);
    cs_pulse();

    // Reset and deselect together: reset wins and clears the address.
    @(negedge clk); reset_n = 1'b0; cs = 1'b1;
    @(negedge clk); reset_n = 1'b1; cs = 1'b0;
    check("reset_over_cs_addr2", d2_addr, 9'h000);
    check("reset_over_cs_addr0", d0_addr, 7'h00);
    idle(4);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
